multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 41 ++++
 rtl/multicycle_control.sv | 167 ++++++++++++++++
 tb/tb_multicycle_control.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared MIPS definitions: opcode constants, ALUOp encodings consumed by
// ALUControlUnit, datapath mux encodings and the controller state codes.
// Ports: none (package).
package multicycle_control_pkg;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_RCOMP  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11
    } state_t;

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller (Moore FSM).
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   Op[5:0]           - IR[31:26], examined in DECODE / MEMADR
//   MemReady          - memory access completes this cycle
//   PCWrite .. RegDst - single-bit datapath controls
//   PCSource, ALUOp, ALUSrcB - 2-bit datapath mux / ALU controls
//   State[3:0]        - current state code (debug)
//   Illegal           - one-cycle pulse when DECODE sees an unsupported opcode
//
// state  | meaning
// -------+--------------------------------------------------
// FETCH  | read instruction, PC+4; waits for MemReady
// DECODE | register read, branch target into ALUOut
// MEMADR | effective address for lw/sw
// MEMRD  | data read; waits for MemReady
// MEMWB  | load result to rt
// MEMWR  | data write; waits for MemReady
// EXEC   | R-type ALU operation
// RCOMP  | R-type result to rd
// BRANCH | beq compare, conditional PC update
// JUMP   | PC <= jump target
// ADDIEX | rs + sign-ext imm
// ADDIWB | addi result to rt
// 12-15  | unreachable; all outputs 0, return to FETCH
import multicycle_control_pkg::*;

module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [3:0] State,
    output logic       Illegal
);

    state_t r_state;
    state_t w_next_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = ST_FETCH;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemtoReg     = 1'b0;
        IRWrite      = 1'b0;
        ALUSrcA      = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        PCSource     = PCSRC_ALU;
        ALUOp        = ALUOP_ADD;
        ALUSrcB      = SRCB_REGB;
        Illegal      = 1'b0;

        case (r_state)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                // The instruction latch and PC+4 only commit on the completing
                // cycle; suppressed during reset so nothing is written then.
                IRWrite = MemReady && !reset;
                PCWrite = MemReady && !reset;
                w_next_state = MemReady ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                ALUSrcB = SRCB_IMM_SH2;
                case (Op)
                    OP_R:          w_next_state = ST_EXEC;
                    OP_LW, OP_SW:  w_next_state = ST_MEMADR;
                    OP_BEQ:        w_next_state = ST_BRANCH;
                    OP_J:          w_next_state = ST_JUMP;
                    OP_ADDI:       w_next_state = ST_ADDIEX;
                    default: begin
                        w_next_state = ST_FETCH;
                        Illegal      = !reset;
                    end
                endcase
            end
            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                if (Op == OP_LW) begin
                    w_next_state = ST_MEMRD;
                end else if (Op == OP_SW) begin
                    w_next_state = ST_MEMWR;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                w_next_state = MemReady ? ST_MEMWB : ST_MEMRD;
            end
            ST_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                w_next_state = MemReady ? ST_FETCH : ST_MEMWR;
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                w_next_state = ST_RCOMP;
            end
            ST_RCOMP: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                w_next_state = ST_FETCH;
            end
            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
                w_next_state = ST_FETCH;
            end
            ST_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                w_next_state = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                RegWrite = 1'b1;
                w_next_state = ST_FETCH;
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    assign State = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst, Illegal;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic [3:0] State;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_control dut (
        .clk         (clk),
        .reset       (reset),
        .Op          (Op),
        .MemReady    (MemReady),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .ALUSrcB     (ALUSrcB),
        .State       (State),
        .Illegal     (Illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; MemReady = 1'b1; Op = 6'd0;
        #1;
        // reset held two cycles
        tick();
        chk4("rst_state", State, 4'd0);
        chk1("rst_memread", MemRead, 1'b1);
        chk1("rst_irwrite", IRWrite, 1'b0);
        chk1("rst_illegal", Illegal, 1'b0);
        tick();
        chk4("rst_state2", State, 4'd0);
        reset = 1'b0;
        #1;
        chk4("post_rst_state", State, 4'd0);
        chk1("post_rst_memread", MemRead, 1'b1);
        chk1("post_rst_irwrite", IRWrite, 1'b1);
        chk1("post_rst_pcwrite", PCWrite, 1'b1);
        chk2("fetch_srcb", ALUSrcB, 2'd1);
        chk1("fetch_iord", IorD, 1'b0);

        // fetch stall
        MemReady = 1'b0; Op = 6'd63;
        #1;
        chk1("fetch_stall_irwrite", IRWrite, 1'b0);
        chk1("fetch_stall_pcwrite", PCWrite, 1'b0);
        chk1("fetch_op63_illegal", Illegal, 1'b0);
        tick();
        chk4("fetch_stall_state", State, 4'd0);

        // lw: 0,1,2,3,4,0
        MemReady = 1'b1; Op = 6'd35;
        tick();
        chk4("lw_s1", State, 4'd1);
        chk2("dec_srcb", ALUSrcB, 2'd3);
        chk1("dec_regwrite", RegWrite, 1'b0);
        chk1("dec_illegal", Illegal, 1'b0);
        tick();
        chk4("lw_s2", State, 4'd2);
        chk1("memadr_srca", ALUSrcA, 1'b1);
        chk2("memadr_srcb", ALUSrcB, 2'd2);
        tick();
        chk4("lw_s3", State, 4'd3);
        chk1("memrd_memread", MemRead, 1'b1);
        chk1("memrd_iord", IorD, 1'b1);
        chk1("memrd_regwrite", RegWrite, 1'b0);
        tick();
        chk4("lw_s4", State, 4'd4);
        chk1("memwb_regwrite", RegWrite, 1'b1);
        chk1("memwb_memtoreg", MemtoReg, 1'b1);
        chk1("memwb_regdst", RegDst, 1'b0);
        tick();
        chk4("lw_s0", State, 4'd0);
        chk1("lw_end_regwrite", RegWrite, 1'b0);

        // sw with three stalled cycles in MEMWR
        Op = 6'd43;
        tick(); tick(); tick();
        chk4("sw_s5", State, 4'd5);
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk4("sw_hold_state", State, 4'd5);
            chk1("sw_hold_memwrite", MemWrite, 1'b1);
            chk1("sw_hold_memread", MemRead, 1'b0);
            tick();
        end
        MemReady = 1'b1;
        #1;
        chk4("sw_last_state", State, 4'd5);
        chk1("sw_last_memwrite", MemWrite, 1'b1);
        tick();
        chk4("sw_done", State, 4'd0);
        chk1("sw_done_memwrite", MemWrite, 1'b0);

        // R-type
        Op = 6'd0;
        tick(); tick();
        chk4("r_s6", State, 4'd6);
        chk2("exec_aluop", ALUOp, 2'd2);
        chk2("exec_srcb", ALUSrcB, 2'd0);
        chk1("exec_srca", ALUSrcA, 1'b1);
        tick();
        chk4("r_s7", State, 4'd7);
        chk1("rcomp_regdst", RegDst, 1'b1);
        chk1("rcomp_regwrite", RegWrite, 1'b1);
        chk1("rcomp_memtoreg", MemtoReg, 1'b0);
        tick();
        chk4("r_s0", State, 4'd0);

        // beq
        Op = 6'd4;
        tick(); tick();
        chk4("beq_s8", State, 4'd8);
        chk1("beq_pcwritecond", PCWriteCond, 1'b1);
        chk2("beq_aluop", ALUOp, 2'd1);
        chk2("beq_pcsource", PCSource, 2'd1);
        chk1("beq_pcwrite", PCWrite, 1'b0);
        tick();
        chk4("beq_s0", State, 4'd0);

        // j
        Op = 6'd2;
        tick(); tick();
        chk4("j_s9", State, 4'd9);
        chk1("j_pcwrite", PCWrite, 1'b1);
        chk2("j_pcsource", PCSource, 2'd2);
        tick();
        chk4("j_s0", State, 4'd0);

        // addi
        Op = 6'd8;
        tick(); tick();
        chk4("addi_s10", State, 4'd10);
        chk2("addiex_srcb", ALUSrcB, 2'd2);
        chk1("addiex_srca", ALUSrcA, 1'b1);
        tick();
        chk4("addi_s11", State, 4'd11);
        chk1("addiwb_regwrite", RegWrite, 1'b1);
        chk1("addiwb_regdst", RegDst, 1'b0);
        tick();
        chk4("addi_s0", State, 4'd0);

        // illegal opcode
        Op = 6'd63;
        tick();
        chk4("ill_s1", State, 4'd1);
        chk1("ill_pulse", Illegal, 1'b1);
        chk1("ill_regwrite", RegWrite, 1'b0);
        chk1("ill_memwrite", MemWrite, 1'b0);
        tick();
        chk4("ill_s0", State, 4'd0);
        chk1("ill_clear", Illegal, 1'b0);

        // reset in the middle of a stalled store
        Op = 6'd43;
        tick(); tick(); tick();
        chk4("rsw_s5", State, 4'd5);
        MemReady = 1'b0;
        tick();
        chk4("rsw_hold", State, 4'd5);
        reset = 1'b1;
        tick();
        chk4("rsw_state", State, 4'd0);
        chk1("rsw_memwrite", MemWrite, 1'b0);
        chk1("rsw_irwrite", IRWrite, 1'b0);
        reset = 1'b0;
        tick();
        chk4("rsw_after", State, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
